// File: rtl/crc32_pkg.sv
// Shared constants and FSM state type for the CRC-32 frame checker and the
// future generator block.
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
    localparam int          CRC32_MIN_LEN   = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } crc32_state_e;

endpackage

// File: rtl/crc32_byte_step.sv
// One-byte reflected CRC-32 update: crc_out = (crc_in >> 8) ^ T[crc_in[7:0] ^ data].
// Computed bit-serially; this unrolls to the same XOR network as the table form.
module crc32_byte_step
    import crc32_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc32_check.sv
// Streaming CRC-32 frame checker: consumes frame bytes (FCS included) and holds a
// registered verdict until the consumer takes it. Optional error counter: CRC32_CHECK_ERRCNT_EN.
module crc32_check
    import crc32_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ok,
    output logic             res_short,
    output logic [LEN_W-1:0] res_len,
    output logic [31:0]      res_residue,
`ifdef CRC32_CHECK_ERRCNT_EN
    output logic [15:0]      err_cnt,
`endif
    output crc32_state_e     dbg_state_o
);

    // Both streams are valid/ready: a transfer happens on the rising edge where
    // valid && ready; the producer keeps its payload stable until then.

    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(CRC32_MIN_LEN);

    crc32_state_e     state_q, state_d;
    logic [31:0]      crc_q, crc_d, crc_base, crc_step;
    logic [LEN_W-1:0] cnt_q, cnt_d, cnt_base, cnt_inc;
    logic             res_valid_q, res_valid_d;
    logic             res_ok_q, res_ok_d;
    logic             res_short_q, res_short_d;
    logic [LEN_W-1:0] res_len_q, res_len_d;
    logic [31:0]      res_residue_q, res_residue_d;
    logic             xfer, res_hs, frame_short;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_BUSY: begin
                if (xfer) begin
                    state_d = in_last ? ST_DONE : ST_BUSY;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. Holding a result blocks input, so the DONE->IDLE cycle never accepts a byte.
    always_comb begin
        in_ready    = !res_valid_q;
        xfer        = in_valid && in_ready;
        res_hs      = res_valid_q && res_ready;
        dbg_state_o = state_q;
    end

    crc32_byte_step u_step (
        .crc_in  (crc_base),
        .data    (in_data),
        .crc_out (crc_step)
    );

    // The first byte of a frame starts from the init value, never from a stale register.
    always_comb begin
        crc_base    = (state_q == ST_BUSY) ? crc_q : CRC32_INIT;
        cnt_base    = (state_q == ST_BUSY) ? cnt_q : '0;
        cnt_inc     = (&cnt_base) ? cnt_base : cnt_base + LEN_W'(1);
        frame_short = (cnt_inc < MIN_LEN);
    end

    always_comb begin
        crc_d         = crc_q;
        cnt_d         = cnt_q;
        res_valid_d   = res_valid_q;
        res_ok_d      = res_ok_q;
        res_short_d   = res_short_q;
        res_len_d     = res_len_q;
        res_residue_d = res_residue_q;
        if (xfer) begin
            if (in_last) begin
                crc_d         = CRC32_INIT;
                cnt_d         = '0;
                res_valid_d   = 1'b1;
                res_len_d     = cnt_inc;
                res_residue_d = crc_step;
                res_short_d   = frame_short;
                res_ok_d      = !frame_short && (crc_step == CRC32_RESIDUE);
            end else begin
                crc_d = crc_step;
                cnt_d = cnt_inc;
            end
        end else if (res_hs) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q         <= CRC32_INIT;
            cnt_q         <= '0;
            res_valid_q   <= 1'b0;
            res_ok_q      <= 1'b0;
            res_short_q   <= 1'b0;
            res_len_q     <= '0;
            res_residue_q <= '0;
        end else begin
            crc_q         <= crc_d;
            cnt_q         <= cnt_d;
            res_valid_q   <= res_valid_d;
            res_ok_q      <= res_ok_d;
            res_short_q   <= res_short_d;
            res_len_q     <= res_len_d;
            res_residue_q <= res_residue_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign res_ok      = res_ok_q;
    assign res_short   = res_short_q;
    assign res_len     = res_len_q;
    assign res_residue = res_residue_q;

`ifdef CRC32_CHECK_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Counts rejected frames as they are handed off; sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (res_hs && !res_ok_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= 16'h0000;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    a_res_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (res_valid && !res_ready) |=> (res_valid && $stable({res_ok, res_short, res_len, res_residue})));

endmodule

// File: tb/tb_crc32_check.sv
// Directed bench for crc32_check; a second instance with LEN_W=3 exercises length saturation.
module tb_crc32_check;
    import crc32_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_last = 1'b0;
    logic res_ready = 1'b0;

    logic in_ready, res_valid, res_ok, res_short;
    logic [15:0] res_len;
    logic [31:0] res_residue;
    crc32_state_e dbg_state;

    logic s_in_ready, s_res_valid, s_res_ok, s_res_short;
    logic [2:0] s_res_len;
    logic [31:0] s_res_residue;
    crc32_state_e s_dbg_state;

`ifdef CRC32_CHECK_ERRCNT_EN
    logic [15:0] err_cnt, s_err_cnt;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] frame_q[$];

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    crc32_check #(.LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .res_valid(res_valid), .res_ready(res_ready),
        .res_ok(res_ok), .res_short(res_short), .res_len(res_len), .res_residue(res_residue),
`ifdef CRC32_CHECK_ERRCNT_EN
        .err_cnt(err_cnt),
`endif
        .dbg_state_o(dbg_state)
    );

    crc32_check #(.LEN_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .res_valid(s_res_valid), .res_ready(res_ready),
        .res_ok(s_res_ok), .res_short(s_res_short), .res_len(s_res_len), .res_residue(s_res_residue),
`ifdef CRC32_CHECK_ERRCNT_EN
        .err_cnt(s_err_cnt),
`endif
        .dbg_state_o(s_dbg_state)
    );

    // Driver tasks
    task automatic load_good();
        frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                    8'h26, 8'h39, 8'hF4, 8'hCB};
    endtask

    // Sends frame_q one byte per accepted cycle; returns at the negedge after the last transfer.
    task automatic send_frame(input bit with_last);
        int n;
        int guard;
        n = frame_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = frame_q[i];
            in_last  = with_last && (i == n - 1);
            guard = 0;
            while (!in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                n_fail++;
                $display("FAIL send_timeout: in_ready stayed %b, want 1", in_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scenarios
    task automatic test_reset();
        in_valid = 1'b0; res_ready = 1'b0; rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", res_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        n_cmp++; if ({res_ok, res_short} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %b want 00", {res_ok, res_short}); end
        n_cmp++; if (res_len !== 16'd0) begin n_fail++; $display("FAIL rst_len: got %0d want 0", res_len); end
        n_cmp++; if (res_residue !== 32'h0) begin n_fail++; $display("FAIL rst_residue: got %h want 0", res_residue); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
    endtask

    task automatic test_good_frame();
        load_good();
        send_frame(1'b1);
        n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL good_latency: res_valid %b want 1", res_valid); end
        n_cmp++; if (res_ok !== 1'b1) begin n_fail++; $display("FAIL good_ok: got %b want 1", res_ok); end
        n_cmp++; if (res_short !== 1'b0) begin n_fail++; $display("FAIL good_short: got %b want 0", res_short); end
        n_cmp++; if (res_len !== 16'd13) begin n_fail++; $display("FAIL good_len: got %0d want 13", res_len); end
        n_cmp++; if (res_residue !== 32'hDEBB20E3) begin n_fail++; $display("FAIL good_residue: got %h want debb20e3", res_residue); end
        n_cmp++; if (s_res_len !== 3'd7) begin n_fail++; $display("FAIL sat_len: got %0d want 7", s_res_len); end
        n_cmp++; if ({s_res_ok, s_res_short} !== 2'b10) begin n_fail++; $display("FAIL sat_flags: got %b want 10", {s_res_ok, s_res_short}); end
        n_cmp++; if (s_res_residue !== 32'hDEBB20E3) begin n_fail++; $display("FAIL sat_residue: got %h want debb20e3", s_res_residue); end
        consume();
        n_cmp++; if ({res_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL good_consume: valid/ready %b want 01", {res_valid, in_ready}); end
    endtask

    task automatic test_corrupt();
        load_good();
        frame_q[4] = 8'h36;
        send_frame(1'b1);
        n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bad_valid: got %b want 1", res_valid); end
        n_cmp++; if ({res_ok, res_short} !== 2'b00) begin n_fail++; $display("FAIL bad_flags: got %b want 00", {res_ok, res_short}); end
        n_cmp++; if (res_len !== 16'd13) begin n_fail++; $display("FAIL bad_len: got %0d want 13", res_len); end
        consume();
    endtask

    task automatic test_short();
        frame_q = '{8'h31, 8'h32, 8'h33};
        send_frame(1'b1);
        n_cmp++; if ({res_valid, res_ok, res_short} !== 3'b101) begin n_fail++; $display("FAIL short3_flags: got %b want 101", {res_valid, res_ok, res_short}); end
        n_cmp++; if (res_len !== 16'd3) begin n_fail++; $display("FAIL short3_len: got %0d want 3", res_len); end
        consume();
        frame_q = '{8'hA5};
        send_frame(1'b1);
        n_cmp++; if ({res_valid, res_ok, res_short} !== 3'b101) begin n_fail++; $display("FAIL short1_flags: got %b want 101", {res_valid, res_ok, res_short}); end
        n_cmp++; if (res_len !== 16'd1) begin n_fail++; $display("FAIL short1_len: got %0d want 1", res_len); end
        n_cmp++; if (dbg_state !== ST_DONE) begin n_fail++; $display("FAIL short1_state: got %0d want DONE", dbg_state); end
        consume();
    endtask

    task automatic test_backpressure();
        load_good();
        send_frame(1'b1);
        in_valid = 1'b1; in_data = 8'h31; in_last = 1'b0; res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({in_ready, res_valid, res_ok, res_len, res_residue} !== {1'b0, 1'b1, 1'b1, 16'd13, 32'hDEBB20E3}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: ready %b valid %b ok %b len %0d res %h want 0 1 1 13 debb20e3",
                         k, in_ready, res_valid, res_ok, res_len, res_residue);
            end
        end
        // Handshake cycle with in_valid still high must not accept the byte.
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        in_valid  = 1'b0;
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL bp_no_accept: state %0d want IDLE", dbg_state); end
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: res_valid %b want 0", res_valid); end
        send_frame(1'b1);
        n_cmp++; if ({res_ok, res_len} !== {1'b1, 16'd13}) begin n_fail++; $display("FAIL bp_next: ok %b len %0d want 1 13", res_ok, res_len); end
        consume();
    endtask

    task automatic test_reset_mid();
        frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        send_frame(1'b0);
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if ({res_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL rstmid_valid%0d: valid/ready %b want 01", k, {res_valid, in_ready}); end
        end
        load_good();
        send_frame(1'b1);
        n_cmp++; if ({res_valid, res_ok, res_len} !== {1'b1, 1'b1, 16'd13}) begin n_fail++; $display("FAIL rstmid_good: valid %b ok %b len %0d want 1 1 13", res_valid, res_ok, res_len); end
        consume();
        frame_q = '{8'h11, 8'h22, 8'h33};
        send_frame(1'b1);
        pulse_reset();
        n_cmp++; if ({res_valid, res_short, res_len} !== {1'b0, 1'b0, 16'd0}) begin n_fail++; $display("FAIL rstdone: valid %b short %b len %0d want 0 0 0", res_valid, res_short, res_len); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] stream[26];
        int idx;
        int cycles;
        int results;
        bit acc;
        load_good();
        for (int i = 0; i < 26; i++) stream[i] = frame_q[i % 13];
        idx = 0; cycles = 0; results = 0;
        res_ready = 1'b1;
        while (idx < 26 && cycles < 100) begin
            @(negedge clk);
            if (res_valid) begin
                results++;
                n_cmp++; if ({res_ok, res_len} !== {1'b1, 16'd13}) begin n_fail++; $display("FAIL b2b_res1: ok %b len %0d want 1 13", res_ok, res_len); end
            end
            in_valid = 1'b1;
            in_data  = stream[idx];
            in_last  = ((idx % 13) == 12);
            acc = in_ready;
            @(posedge clk);
            if (acc) idx++;
            cycles++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_cmp++; if (cycles !== 27) begin n_fail++; $display("FAIL b2b_cycles: got %0d want 27", cycles); end
        n_cmp++; if (results !== 1) begin n_fail++; $display("FAIL b2b_mid_results: got %0d want 1", results); end
        n_cmp++; if ({res_valid, res_ok, res_len} !== {1'b1, 1'b1, 16'd13}) begin n_fail++; $display("FAIL b2b_res2: valid %b ok %b len %0d want 1 1 13", res_valid, res_ok, res_len); end
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: res_valid %b want 0", res_valid); end
    endtask

`ifdef CRC32_CHECK_ERRCNT_EN
    task automatic test_errcnt();
        pulse_reset();
        n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL err_rst: got %0d want 0", err_cnt); end
        for (int f = 0; f < 3; f++) begin
            if (f < 2) frame_q = '{8'h31, 8'h32, 8'h33};
            else load_good();
            send_frame(1'b1);
            consume();
        end
        n_cmp++; if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL err_two: got %0d want 2", err_cnt); end
        force dut.err_cnt_q = 16'hFFFE;
        #1;
        release dut.err_cnt_q;
        for (int f = 0; f < 3; f++) begin
            frame_q = '{8'h55};
            send_frame(1'b1);
            consume();
        end
        n_cmp++; if (err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL err_sat: got %h want ffff", err_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame();
        test_corrupt();
        test_short();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef CRC32_CHECK_ERRCNT_EN
        test_errcnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/crc32_check.md
CRC32_CHECK -- requirements
Module: crc32_check

Interface
REQ-001 The block SHALL have parameter LEN_W, default 16: width of the frame byte counter and of res_len.
REQ-002 The block SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1: in_data, in_last are valid.
REQ-005 The block SHALL have port in_ready, output, 1: block accepts a byte this cycle.
REQ-006 The block SHALL have port in_data, input, 8: frame byte, including the 4 trailing FCS bytes (FCS sent LSB first).
REQ-007 The block SHALL have port in_last, input, 1: marks the final byte of the frame.
REQ-008 The block SHALL have port res_valid, output, 1: a frame result is held.
REQ-009 The block SHALL have port res_ready, input, 1: consumer takes the result.
REQ-010 The block SHALL have port res_ok, output, 1: residue matched and frame not short.
REQ-011 The block SHALL have port res_short, output, 1: frame had fewer than 5 bytes.
REQ-012 The block SHALL have port res_len, output, LEN_W: total bytes accepted in the frame, FCS included.
REQ-013 The block SHALL have port res_residue, output, 32: final CRC register value.

Function
REQ-014 The CRC SHALL be reflected CRC-32: polynomial 0xEDB88320, register init 0xFFFFFFFF, per byte crc_next = (crc >> 8) ^ T[crc[7:0] ^ in_data].
REQ-015 A byte transfer SHALL occur only when in_valid && in_ready; in_ready SHALL equal !res_valid.
REQ-016 The FSM SHALL have states IDLE (no frame), BUSY (frame open) and DONE (result held).
REQ-017 FSM transitions: IDLE->BUSY on a transfer with !in_last; IDLE/BUSY->DONE on a transfer with in_last; DONE->IDLE when res_ready; otherwise hold state.
REQ-018 The first transfer of a frame SHALL use the init value, not the previous frame's register.
REQ-019 res_valid and all res_* outputs SHALL be registered and SHALL rise exactly one cycle after the in_last transfer; the result latency is 1.
REQ-020 res_* outputs SHALL stay stable while res_valid && !res_ready.
REQ-021 res_ok SHALL be 1 iff the register after the last byte equals 0xDEBB20E3 and res_len >= 5.
REQ-022 res_short SHALL be 1 iff res_len < 5; in that case res_ok SHALL be 0.
REQ-023 res_len SHALL saturate at 2^LEN_W-1; CRC computation SHALL continue past saturation.
REQ-024 A single-byte frame (in_last on the first byte) SHALL yield res_len=1, res_short=1, res_ok=0.
REQ-025 In DONE, a cycle with res_ready=1 and in_valid=1 SHALL NOT accept the byte; the byte is accepted earliest in the following cycle.
REQ-026 Back-to-back frames SHALL sustain one byte per cycle, except one stall cycle per frame in DONE when res_ready is held high.

Reset
REQ-027 On rst_n=0 at a clk edge: state=IDLE, CRC register=0xFFFFFFFF, byte count=0, res_valid=0, res_ok=0, res_short=0, res_len=0, res_residue=0, in_ready=1 from the next cycle.
REQ-028 Reset mid-frame or in DONE SHALL discard the partial frame or pending result without producing a result.

Configuration
REQ-029 With macro CRC32_CHECK_ERRCNT_EN defined, the block SHALL add output err_cnt[15:0], reset to 0, incremented on each result handshake (res_valid && res_ready) with res_ok=0, saturating at 0xFFFF.
REQ-030 Without CRC32_CHECK_ERRCNT_EN, port err_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package crc32_pkg SHALL hold CRC32_POLY_REFL (0xEDB88320), CRC32_INIT (0xFFFFFFFF), CRC32_RESIDUE (0xDEBB20E3), CRC32_MIN_LEN (5) and the FSM state enum.
REQ-032 The per-byte update SHALL be a combinational sub-module crc32_byte_step (crc_in[31:0], data[7:0] -> crc_out[31:0]), so the future generator block can share it.

Verification
REQ-033 Scenario good frame: "123456789" then bytes 26 39 F4 CB, in_last on CB -> one cycle later res_valid=1, res_ok=1, res_len=13, res_residue=0xDEBB20E3.
REQ-034 Scenario corrupted frame: same frame with '5' replaced by '6' -> res_ok=0, res_short=0, res_len=13.
REQ-035 Scenario short frames: 3-byte frame -> res_short=1, res_ok=0, res_len=3; 1-byte frame -> res_len=1, res_short=1.
REQ-036 Scenario backpressure: res_ready=0 for 5 cycles after a result while in_valid=1 -> in_ready=0, no byte consumed, res_* stable; the next frame starts with the init value and gives a correct result.
REQ-037 Scenario reset: rst_n=0 after 6 bytes of a frame -> no res_valid; a subsequent good frame gives res_ok=1.
REQ-038 Scenario error counter (CRC32_CHECK_ERRCNT_EN defined): two bad frames and one good frame -> err_cnt=2; with the counter preloaded to near saturation, additional bad frames -> err_cnt holds at 0xFFFF.
